// File: rtl/list_fetch_ctrl_if.sv
// Command, read-port and list_cache signals of list_fetch_ctrl.
// slave = the fetch controller; master = whoever drives commands and memory responses.
interface list_fetch_ctrl_if #(
  parameter int TYPE_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [LEN_WIDTH-1:0]  list_len;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic                  rd_req_valid;
  logic                  rd_req_ready;
  logic [ADDR_WIDTH-1:0] rd_req_addr;
  logic                  rd_resp_valid;
  logic [TYPE_WIDTH-1:0] rd_resp_data;
  logic [TYPE_WIDTH-1:0] list_in;
  logic                  list_next_ready;
  logic                  arg_received;

  modport slave (
    input  start, base_addr, list_len, rd_req_ready, rd_resp_valid, rd_resp_data, arg_received,
    output busy, done, err, rd_req_valid, rd_req_addr, list_in, list_next_ready
  );

  modport master (
    output start, base_addr, list_len, rd_req_ready, rd_resp_valid, rd_resp_data, arg_received,
    input  busy, done, err, rd_req_valid, rd_req_addr, list_in, list_next_ready
  );
endinterface

// File: rtl/list_fetch_ctrl.sv
// Fetches a list of elements over the read port into list_cache, never holding more than
// BUFFER_SIZE unconsumed elements; response-to-LIST_IN latency is one cycle.
module list_fetch_ctrl #(
  parameter int TYPE_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int LEN_WIDTH   = 16,
  parameter int BUFFER_SIZE = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  list_fetch_ctrl_if.slave   lf_if
);

  localparam int CW = LEN_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(TYPE_WIDTH / 8);
  localparam logic [CW-1:0] BUF_DEPTH = CW'(BUFFER_SIZE);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CW-1:0]         len_q, len_d;
  logic [CW-1:0]         req_q, req_d;
  logic [CW-1:0]         resp_q, resp_d;
  logic [CW-1:0]         cons_q, cons_d;
  logic                  err_q, err_d;
  logic [TYPE_WIDTH-1:0] data_q, data_d;
  logic                  nrdy_q, nrdy_d;

  logic          active;
  logic [CW-1:0] outstanding;
  logic          req_vld;
  logic          req_fire;
  logic          resp_fire;
  logic          resp_err;
  logic          arg_fire;
  logic          arg_err;

  assign active      = (state_q == S_FETCH) || (state_q == S_DRAIN);
  assign outstanding = req_q - cons_q;
  // VALID depends only on registered state; nothing but an accept can drop it once raised.
  assign req_vld     = (state_q == S_FETCH) && (req_q < len_q) && (outstanding < BUF_DEPTH);
  assign req_fire    = req_vld && lf_if.rd_req_ready;
  assign resp_fire   = active && lf_if.rd_resp_valid && (resp_q < req_q);
  assign resp_err    = active && lf_if.rd_resp_valid && (resp_q == req_q);
  assign arg_fire    = active && lf_if.arg_received && (cons_q < resp_q);
  assign arg_err     = lf_if.arg_received && !arg_fire;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    req_d   = req_q;
    resp_d  = resp_q;
    cons_d  = cons_q;
    err_d   = err_q;
    data_d  = data_q;
    nrdy_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (lf_if.start) begin
          err_d   = 1'b0;
          addr_d  = lf_if.base_addr;
          len_d   = CW'(lf_if.list_len);
          req_d   = '0;
          resp_d  = '0;
          cons_d  = '0;
          state_d = (lf_if.list_len != '0) ? S_FETCH : S_DONE;
        end
      end
      S_FETCH: if (req_q == len_q) state_d = S_DRAIN;
      S_DRAIN: if ((resp_q == len_q) && (cons_q == len_q)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (req_fire) begin
      req_d  = req_q + 1'b1;
      addr_d = addr_q + STRIDE;
    end
    if (resp_fire) begin
      resp_d = resp_q + 1'b1;
      data_d = lf_if.rd_resp_data;
      nrdy_d = 1'b1;
    end
    if (arg_fire) cons_d = cons_q + 1'b1;
    if (resp_err || arg_err) err_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      req_q   <= '0;
      resp_q  <= '0;
      cons_q  <= '0;
      err_q   <= 1'b0;
      data_q  <= '0;
      nrdy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      req_q   <= req_d;
      resp_q  <= resp_d;
      cons_q  <= cons_d;
      err_q   <= err_d;
      data_q  <= data_d;
      nrdy_q  <= nrdy_d;
    end
  end

  assign lf_if.busy            = active;
  assign lf_if.done            = (state_q == S_DONE);
  assign lf_if.err             = err_q;
  assign lf_if.rd_req_valid    = req_vld;
  assign lf_if.rd_req_addr     = addr_q;
  assign lf_if.list_in         = data_q;
  assign lf_if.list_next_ready = nrdy_q;

endmodule

// File: tb/tb_list_fetch_ctrl.sv
// Directed bench for list_fetch_ctrl: inputs driven and outputs sampled on the falling edge.
module tb_list_fetch_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   acc;

  always #5 clk = ~clk;

  list_fetch_ctrl_if #(.TYPE_WIDTH(32), .ADDR_WIDTH(32), .LEN_WIDTH(16)) lf ();

  list_fetch_ctrl #(
    .TYPE_WIDTH(32), .ADDR_WIDTH(32), .LEN_WIDTH(16), .BUFFER_SIZE(4)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .lf_if (lf.slave)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (lf.done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(tag, lf.done, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    lf.start = 0; lf.base_addr = '0; lf.list_len = '0; lf.rd_req_ready = 0;
    lf.rd_resp_valid = 0; lf.rd_resp_data = '0; lf.arg_received = 0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", lf.rd_req_valid, 0);
    chk("rst_busy", lf.busy, 0);
    chk("rst_done", lf.done, 0);
    chk("rst_err", lf.err, 0);
    chk("rst_nrdy", lf.list_next_ready, 0);
    chk("rst_list_in", lf.list_in, 0);
    chk("rst_addr", lf.rd_req_addr, 0);
    rst_n = 1'b1;

    // Basic three-element list with responses two cycles after each request.
    @(negedge clk);
    lf.rd_req_ready = 1; lf.start = 1; lf.base_addr = 32'h1000; lf.list_len = 3;
    @(negedge clk);
    lf.start = 0;
    chk("t1_vld0", lf.rd_req_valid, 1);
    chk("t1_addr0", lf.rd_req_addr, 32'h1000);
    chk("t1_busy", lf.busy, 1);
    @(negedge clk);
    chk("t1_addr1", lf.rd_req_addr, 32'h1004);
    @(negedge clk);
    chk("t1_addr2", lf.rd_req_addr, 32'h1008);
    lf.rd_resp_valid = 1; lf.rd_resp_data = 32'hA0A0_0000;
    @(negedge clk);
    chk("t1_vld_end", lf.rd_req_valid, 0);
    chk("t1_nrdy0", lf.list_next_ready, 1);
    chk("t1_data0", lf.list_in, 32'hA0A0_0000);
    lf.rd_resp_data = 32'hA1A1_0001; lf.arg_received = 1;
    @(negedge clk);
    chk("t1_nrdy1", lf.list_next_ready, 1);
    chk("t1_data1", lf.list_in, 32'hA1A1_0001);
    lf.rd_resp_data = 32'hA2A2_0002;
    @(negedge clk);
    chk("t1_data2", lf.list_in, 32'hA2A2_0002);
    lf.rd_resp_valid = 0;
    @(negedge clk);
    lf.arg_received = 0;
    chk("t1_not_done_yet", lf.done, 0);
    chk("t1_busy_drain", lf.busy, 1);
    chk("t1_nrdy_low", lf.list_next_ready, 0);
    chk("t1_data_hold", lf.list_in, 32'hA2A2_0002);
    @(negedge clk);
    chk("t1_done", lf.done, 1);
    chk("t1_busy_off", lf.busy, 0);
    chk("t1_err", lf.err, 0);
    @(negedge clk);
    chk("t1_done_pulse", lf.done, 0);

    // Credit limit: six elements, nobody consumes.
    lf.start = 1; lf.base_addr = 32'h2000; lf.list_len = 6;
    @(negedge clk);
    lf.start = 0;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      if (lf.rd_req_valid) acc++;
      @(negedge clk);
    end
    chk("t2_accepted", acc, 4);
    chk("t2_vld_stall", lf.rd_req_valid, 0);
    for (int i = 0; i < 4; i++) begin
      lf.rd_resp_valid = 1; lf.rd_resp_data = 32'hB0 + i;
      @(negedge clk);
    end
    lf.rd_resp_valid = 0;
    chk("t2_last_data", lf.list_in, 32'hB3);
    chk("t2_still_stall", lf.rd_req_valid, 0);
    lf.arg_received = 1;
    @(negedge clk);
    lf.arg_received = 0;
    chk("t2_fifth_vld", lf.rd_req_valid, 1);
    chk("t2_fifth_addr", lf.rd_req_addr, 32'h2010);
    chk("t2_err", lf.err, 0);
    rst_n = 0; lf.rd_req_ready = 0;
    @(negedge clk);
    rst_n = 1;

    // Back-pressure on the request port.
    @(negedge clk);
    lf.start = 1; lf.base_addr = 32'h1000; lf.list_len = 1;
    @(negedge clk);
    lf.start = 0;
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_vld", lf.rd_req_valid, 1);
      chk("t3_hold_addr", lf.rd_req_addr, 32'h1000);
      @(negedge clk);
    end
    lf.rd_req_ready = 1;
    @(negedge clk);
    lf.rd_req_ready = 0;
    chk("t3_one_accept", lf.rd_req_valid, 0);
    lf.rd_resp_valid = 1; lf.rd_resp_data = 32'hC0C0_C0C0;
    @(negedge clk);
    lf.rd_resp_valid = 0;
    chk("t3_data", lf.list_in, 32'hC0C0_C0C0);
    chk("t3_nrdy", lf.list_next_ready, 1);
    lf.arg_received = 1;
    @(negedge clk);
    lf.arg_received = 0;
    wait_done("t3_done");
    @(negedge clk);

    // Empty list, then START while busy.
    lf.start = 1; lf.base_addr = 32'h5000; lf.list_len = 0;
    @(negedge clk);
    lf.start = 0;
    chk("t4_empty_done", lf.done, 1);
    chk("t4_empty_vld", lf.rd_req_valid, 0);
    chk("t4_empty_busy", lf.busy, 0);
    @(negedge clk);
    chk("t4_empty_pulse", lf.done, 0);
    chk("t4_empty_vld2", lf.rd_req_valid, 0);
    lf.start = 1; lf.base_addr = 32'h6000; lf.list_len = 1;
    @(negedge clk);
    lf.base_addr = 32'h7000; lf.list_len = 5;
    @(negedge clk);
    lf.start = 0;
    chk("t4_busy_base", lf.rd_req_addr, 32'h6000);
    chk("t4_busy", lf.busy, 1);
    lf.rd_req_ready = 1;
    @(negedge clk);
    lf.rd_req_ready = 0;
    chk("t4_len_kept", lf.rd_req_valid, 0);
    lf.rd_resp_valid = 1; lf.rd_resp_data = 32'hD0D0_D0D0;
    @(negedge clk);
    lf.rd_resp_valid = 0; lf.arg_received = 1;
    @(negedge clk);
    lf.arg_received = 0;
    wait_done("t4_done");
    chk("t4_err", lf.err, 0);
    @(negedge clk);
    chk("t4_idle", lf.busy, 0);

    // Protocol errors.
    lf.arg_received = 1;
    @(negedge clk);
    lf.arg_received = 0;
    chk("t5_idle_arg_err", lf.err, 1);
    chk("t5_idle_busy", lf.busy, 0);
    lf.start = 1; lf.base_addr = 32'h8000; lf.list_len = 2;
    @(negedge clk);
    lf.start = 0;
    chk("t5_start_clears", lf.err, 0);
    lf.arg_received = 1;
    @(negedge clk);
    lf.arg_received = 0;
    chk("t5_arg_err", lf.err, 1);
    chk("t5_vld", lf.rd_req_valid, 1);
    chk("t5_addr", lf.rd_req_addr, 32'h8000);
    lf.rd_resp_valid = 1; lf.rd_resp_data = 32'hEEEE_EEEE;
    @(negedge clk);
    lf.rd_resp_valid = 0;
    chk("t5_spurious_nrdy", lf.list_next_ready, 0);
    chk("t5_spurious_data", lf.list_in, 32'hD0D0_D0D0);
    chk("t5_err_sticky", lf.err, 1);
    lf.rd_req_ready = 1;
    @(negedge clk);
    chk("t5_addr1", lf.rd_req_addr, 32'h8004);
    @(negedge clk);
    chk("t5_vld_end", lf.rd_req_valid, 0);
    lf.rd_req_ready = 0; lf.rd_resp_valid = 1; lf.rd_resp_data = 32'hE0;
    @(negedge clk);
    chk("t5_data0", lf.list_in, 32'hE0);
    chk("t5_nrdy0", lf.list_next_ready, 1);
    lf.rd_resp_data = 32'hE1;
    @(negedge clk);
    chk("t5_data1", lf.list_in, 32'hE1);
    lf.rd_resp_valid = 0; lf.arg_received = 1;
    @(negedge clk);
    @(negedge clk);
    lf.arg_received = 0;
    wait_done("t5_done");
    chk("t5_err_after_done", lf.err, 1);
    @(negedge clk);
    lf.start = 1; lf.list_len = 0;
    @(negedge clk);
    lf.start = 0;
    chk("t5_empty_done", lf.done, 1);
    chk("t5_err_cleared", lf.err, 0);

    // Reset mid-fetch with two reads outstanding.
    @(negedge clk);
    lf.start = 1; lf.base_addr = 32'h9000; lf.list_len = 4; lf.rd_req_ready = 1;
    @(negedge clk);
    lf.start = 0;
    chk("t6_vld", lf.rd_req_valid, 1);
    @(negedge clk);
    @(negedge clk);
    chk("t6_addr2", lf.rd_req_addr, 32'h9008);
    #2 rst_n = 0;
    #1;
    chk("t6_rst_vld", lf.rd_req_valid, 0);
    chk("t6_rst_busy", lf.busy, 0);
    chk("t6_rst_addr", lf.rd_req_addr, 0);
    chk("t6_rst_done", lf.done, 0);
    @(negedge clk);
    rst_n = 1; lf.rd_req_ready = 0;
    lf.rd_resp_valid = 1; lf.rd_resp_data = 32'hF0F0_F0F0;
    @(negedge clk);
    lf.rd_resp_data = 32'hF1F1_F1F1;
    @(negedge clk);
    lf.rd_resp_valid = 0;
    chk("t6_late_nrdy", lf.list_next_ready, 0);
    chk("t6_late_data", lf.list_in, 0);
    chk("t6_late_err", lf.err, 0);
    chk("t6_late_busy", lf.busy, 0);

    // Address wrap.
    lf.start = 1; lf.base_addr = 32'hFFFF_FFFC; lf.list_len = 2; lf.rd_req_ready = 1;
    @(negedge clk);
    lf.start = 0;
    chk("t6_wrap_addr0", lf.rd_req_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    chk("t6_wrap_addr1", lf.rd_req_addr, 32'h0000_0000);
    @(negedge clk);
    chk("t6_wrap_vld_end", lf.rd_req_valid, 0);
    lf.rd_req_ready = 0; lf.rd_resp_valid = 1; lf.rd_resp_data = 32'h11;
    @(negedge clk);
    lf.rd_resp_data = 32'h22; lf.arg_received = 1;
    @(negedge clk);
    lf.rd_resp_valid = 0;
    chk("t6_wrap_data1", lf.list_in, 32'h22);
    @(negedge clk);
    lf.arg_received = 0;
    wait_done("t6_wrap_done");
    chk("t6_wrap_err", lf.err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
